// File: rtl/udp_rx_demux.sv
// UDP receive demultiplexer: parses Ethernet/IPv4/UDP headers from a MAC byte
// stream, filters on station MAC/IP and a list of listen ports, and streams the
// payload of an accepted datagram onto the matching channel strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first byte of a frame (only when armed)
// ETH_HDR  | bytes 1-13: destination MAC and EtherType checks
// IP_HDR   | bytes 14-33: IPv4 header checks and header checksum
// UDP_HDR  | bytes 34-41: source/destination port, UDP length
// PAYLOAD  | streaming payload bytes to the matched channel
// WAIT_END | payload done or truncated; waiting for good/bad end pulse
// DROP     | frame rejected; waiting for the strobe to fall
module udp_rx_demux #(
  parameter int                        NUM_PORTS = 4,
  // channel 0 sits in the low slice, so 4661 is channel 1
  parameter logic [NUM_PORTS*16-1:0]   PORT_LIST = {16'd4663, 16'd4662, 16'd4661, 16'd4660},
  parameter logic [47:0]               MY_MAC    = 48'h00AABBCCDDEE,
  parameter logic [31:0]               MY_IP     = 32'h0A050505
) (
  input  logic                 eth_rx_clk,
  input  logic                 eth_rx_rst_n,
  input  logic [7:0]           eth_rx_data,
  input  logic                 eth_rx_data_valid,
  input  logic                 eth_rx_frame_good,
  input  logic                 eth_rx_frame_bad,
  output logic [7:0]           udp_rx,
  output logic [NUM_PORTS-1:0] udp_rx_dv,
  output logic                 udp_rx_sof,
  output logic                 udp_rx_eof,
  output logic                 udp_rx_commit,
  output logic                 udp_rx_abort,
  output logic [31:0]          udp_rx_src_ip,
  output logic [15:0]          udp_rx_src_port,
  output logic [15:0]          udp_rx_len,
  output logic [15:0]          stat_drop_cnt
);

  typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END, DROP} state_t;

  state_t         state_q;
  logic [15:0]    pos_q, cnt_q, csum_q;
  logic [7:0]     hi_q;
  logic [2:0]     chan_q;
  logic           armed_q, my_ok_q, bc_ok_q, trunc_q, has_data_q;

  logic [15:0]    pos_cur, word_d, csum_d;
  logic [16:0]    sum17;
  logic [7:0]     mac_byte, ip_byte;
  logic [2:0]     mac_idx, port_idx_d;
  logic [1:0]     ip_idx;
  logic           my_ok_d, bc_ok_d, port_hit_d, ip_bad_d;
  logic [NUM_PORTS-1:0] dv_onehot;

  // Per-byte header decode helpers: field compares, checksum and port lookup
  always_comb begin
    pos_cur  = (state_q == IDLE) ? 16'd0 : pos_q;
    word_d   = {hi_q, eth_rx_data};
    mac_idx  = 3'd5 - pos_cur[2:0];
    mac_byte = MY_MAC[{mac_idx, 3'b000} +: 8];
    ip_idx   = 2'd1 - pos_cur[1:0];
    ip_byte  = MY_IP[{ip_idx, 3'b000} +: 8];
    my_ok_d  = ((state_q == IDLE) ? 1'b1 : my_ok_q) & (eth_rx_data == mac_byte);
    bc_ok_d  = ((state_q == IDLE) ? 1'b1 : bc_ok_q) & (eth_rx_data == 8'hFF);
    // header checksum folded per word so the running sum stays 16 bits
    sum17    = {1'b0, csum_q} + {1'b0, word_d};
    csum_d   = sum17[15:0] + {15'd0, sum17[16]};
    ip_bad_d = (pos_q == 16'd14 && eth_rx_data != 8'h45) ||
               (pos_q == 16'd20 && (eth_rx_data & 8'h3F) != 8'h00) ||
               (pos_q == 16'd21 && eth_rx_data != 8'h00) ||
               (pos_q == 16'd23 && eth_rx_data != 8'h11) ||
               (pos_q >= 16'd30 && eth_rx_data != ip_byte) ||
               (pos_q == 16'd33 && csum_d != 16'hFFFF);
    port_hit_d = 1'b0;
    port_idx_d = 3'd0;
    // descending scan so the lowest matching channel wins
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (PORT_LIST[16*i +: 16] == word_d) begin
        port_hit_d = 1'b1;
        port_idx_d = 3'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) dv_onehot[i] = (chan_q == 3'(i));
  end

  // Receive FSM with registered outputs
  always_ff @(posedge eth_rx_clk or negedge eth_rx_rst_n) begin
    if (!eth_rx_rst_n) begin
      state_q <= IDLE;  pos_q <= '0;  cnt_q <= '0;  csum_q <= '0;  hi_q <= '0;
      chan_q <= '0;  armed_q <= 1'b0;  my_ok_q <= 1'b0;  bc_ok_q <= 1'b0;
      trunc_q <= 1'b0;  has_data_q <= 1'b0;
      udp_rx <= '0;  udp_rx_dv <= '0;  udp_rx_sof <= 1'b0;  udp_rx_eof <= 1'b0;
      udp_rx_commit <= 1'b0;  udp_rx_abort <= 1'b0;  udp_rx_src_ip <= '0;
      udp_rx_src_port <= '0;  udp_rx_len <= '0;  stat_drop_cnt <= '0;
    end else begin
      udp_rx_dv     <= '0;
      udp_rx_sof    <= 1'b0;
      udp_rx_eof    <= 1'b0;
      udp_rx_commit <= 1'b0;
      udp_rx_abort  <= 1'b0;
      if (!eth_rx_data_valid) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (eth_rx_data_valid && armed_q) begin
            armed_q <= 1'b0;
            pos_q   <= 16'd1;
            my_ok_q <= my_ok_d;
            bc_ok_q <= bc_ok_d;
            csum_q  <= '0;
            trunc_q <= 1'b0;
            state_q <= (my_ok_d || bc_ok_d) ? ETH_HDR : DROP;
          end
        end
        ETH_HDR, IP_HDR, UDP_HDR: begin
          if (!eth_rx_data_valid) begin
            if (stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
            state_q <= IDLE;
          end else begin
            pos_q <= pos_q + 16'd1;
            if (!pos_q[0]) hi_q <= eth_rx_data;
            if (state_q == ETH_HDR) begin
              if (pos_q < 16'd6) begin
                my_ok_q <= my_ok_d;
                bc_ok_q <= bc_ok_d;
              end
              if (pos_q == 16'd5 && !(my_ok_d || bc_ok_d)) state_q <= DROP;
              else if (pos_q == 16'd12 && eth_rx_data != 8'h08) state_q <= DROP;
              else if (pos_q == 16'd13) state_q <= (eth_rx_data == 8'h00) ? IP_HDR : DROP;
            end else if (state_q == IP_HDR) begin
              if (pos_q[0]) csum_q <= csum_d;
              if (pos_q >= 16'd26 && pos_q <= 16'd29)
                udp_rx_src_ip <= {udp_rx_src_ip[23:0], eth_rx_data};
              if (ip_bad_d) state_q <= DROP;
              else if (pos_q == 16'd33) state_q <= UDP_HDR;
            end else begin
              if (pos_q == 16'd35) udp_rx_src_port <= word_d;
              if (pos_q == 16'd37) begin
                chan_q <= port_idx_d;
                if (!port_hit_d) state_q <= DROP;
              end
              if (pos_q == 16'd39) begin
                udp_rx_len <= word_d - 16'd8;
                if (word_d < 16'd8) state_q <= DROP;
              end
              if (pos_q == 16'd41) begin
                cnt_q      <= '0;
                has_data_q <= (udp_rx_len != 16'd0);
                state_q    <= (udp_rx_len == 16'd0) ? WAIT_END : PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (!eth_rx_data_valid) begin
            trunc_q <= 1'b1;
            // an end pulse coinciding with the fall can only mean discard
            if (eth_rx_frame_good || eth_rx_frame_bad) begin
              udp_rx_abort <= 1'b1;
              state_q      <= IDLE;
            end else begin
              state_q <= WAIT_END;
            end
          end else begin
            udp_rx     <= eth_rx_data;
            udp_rx_dv  <= dv_onehot;
            udp_rx_sof <= (cnt_q == 16'd0);
            udp_rx_eof <= (cnt_q == udp_rx_len - 16'd1);
            cnt_q      <= cnt_q + 16'd1;
            if (cnt_q == udp_rx_len - 16'd1) state_q <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (eth_rx_frame_good || eth_rx_frame_bad) begin
            if (has_data_q) begin
              if (eth_rx_frame_good && !eth_rx_frame_bad && !trunc_q) udp_rx_commit <= 1'b1;
              else udp_rx_abort <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        DROP: begin
          if (!eth_rx_data_valid) begin
            if (stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
